writeback_vec: RTL
==================

Name: writeback_vec

Overview:
- Write-back stage of the vector pipeline; the writer for the Decode-stage register-file reader.
- Takes the Memory-stage result, an ALU vector or a vector load, and drives the register-file write port: RegWriteW, wa3w, wd3.
- Vector loads arrive from the 18-bit data memory one lane per beat. The block assembles the lanes and back-pressures the Memory stage until the load commits.

Parameters:
- WIDTH, 18, lane width in bits
- LANES, 3, lanes per vector register
- ADDR, 4, register address width (register 15 = PC)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ValidM  in  1  Memory-stage instruction valid
- RegWriteM  in  1  instruction writes a register
- MemtoRegM  in  1  result comes from memory, not ALU
- wa3m  in  ADDR  destination register
- ALUResultM  in  [LANES-1:0][WIDTH-1:0]  ALU vector result
- ReadDataM  in  WIDTH  one memory lane
- ReadValidM  in  1  ReadDataM valid this cycle
- StallM  out  1  Memory stage must hold its outputs
- RegWriteW  out  1  register-file write enable (one-cycle pulse)
- wa3w  out  ADDR  write address
- wd3  out  [LANES-1:0][WIDTH-1:0]  write data
- PCWriteW  out  1  RegWriteW && wa3w == all-ones

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- Reset values: state=IDLE, lane_cnt=0, StallM=0, RegWriteW=0, PCWriteW=0, wa3w=0, wd3=0.
- States: IDLE, LOAD, COMMIT.
- IDLE, ALU op: ValidM && RegWriteM && !MemtoRegM.
  - Next cycle: RegWriteW=1, wa3w=wa3m, wd3=ALUResultM.
  - Latency 1; back-to-back ALU ops write every cycle.
- IDLE, no write: ValidM && !RegWriteM && !MemtoRegM → no write.
- IDLE, load: ValidM && MemtoRegM.
  - Capture wa3m and RegWriteM, clear lane_cnt, go to LOAD.
  - No write is issued this cycle.
- LOAD: StallM=1 (StallM = state==LOAD, registered state).
  - Each cycle with ReadValidM=1: lane[lane_cnt] <= ReadDataM, lane_cnt++.
  - ReadValidM=0 waits indefinitely.
- LOAD exit: when the beat with lane_cnt==LANES-1 is accepted, go to COMMIT.
- COMMIT (one cycle):
  - RegWriteW = captured RegWriteM; wa3w = captured address; wd3 = assembled lanes (lane 0 = first beat).
  - StallM=0, so a new ValidM instruction is accepted in this cycle using the IDLE rules.
  - The next state and any write follow in the next cycle.
- Load latency: last beat → RegWriteW one cycle later.
- Load with RegWriteM=0: lanes are still drained (consumes LANES beats), no write pulse.
- Ignored inputs:
  - ReadValidM in IDLE or COMMIT is ignored.
  - ValidM in LOAD is ignored; Memory stage holds because of StallM.
- Between writes: wa3w and wd3 hold their last values. RegWriteW and PCWriteW are 0 except in the write cycle.
- PCWriteW asserts with RegWriteW when the address is 4'b1111.
- rst mid-load: abort the load, discard partial lanes, return to IDLE, no write issued.

Optional Feature:
- Macro: WB_LANE_MASK_EN.
- When defined:
  - Adds input LaneMaskM [LANES-1:0] and output WeLaneW [LANES-1:0].
  - The mask is captured with the instruction (ALU op or load start).
  - WeLaneW presents the captured mask during the write cycle and is 0 otherwise.
  - Masked-off lanes of wd3 are 0.
  - Loads still consume LANES beats.
- When undefined: neither port exists; all lanes are written.

Test Plan:
- ALU write: ValidM=1, RegWriteM=1, MemtoRegM=0, wa3m=3, ALUResultM={18'h1, 18'h2, 18'h3} → next cycle RegWriteW=1, wa3w=3, wd3 = same values; following cycle RegWriteW=0, wd3 holds.
- Load: ValidM, MemtoRegM, RegWriteM, wa3m=5; beats 18'h0AAAA, 18'h15555, 18'h3FFFF with a ReadValidM=0 gap → StallM=1 from the cycle after acceptance until COMMIT; RegWriteW=1 one cycle after the third beat; wd3[0]=18'h0AAAA, wd3[1]=18'h15555, wd3[2]=18'h3FFFF.
- Load without write: RegWriteM=0, three beats → StallM drops after the third beat, RegWriteW never asserts.
- PC write: ALU op with wa3m=4'hF → RegWriteW=1 and PCWriteW=1 in the same cycle.
- Reset mid-load: assert rst after 2 beats → StallM=0 and RegWriteW=0 next cycle; a subsequent load of 3 new beats yields only the new data.
- Back-to-back: load followed immediately by an ALU op held during the stall → load write, then ALU write on the next cycle, with no lost or duplicated RegWriteW pulse.

Source files
------------

// File: rtl/writeback_vec_if.sv
// Memory-stage to write-back bundle, plus the register-file write port the stage drives.
// WB_LANE_MASK_EN adds the per-lane write mask (LaneMaskM in, WeLaneW out).
interface writeback_vec_if #(
   parameter int WIDTH = 18,
   parameter int LANES = 3,
   parameter int ADDR  = 4
);
   logic                         ValidM;
   logic                         RegWriteM;
   logic                         MemtoRegM;
   logic [ADDR-1:0]              wa3m;
   logic [LANES-1:0][WIDTH-1:0]  ALUResultM;
   logic [WIDTH-1:0]             ReadDataM;
   logic                         ReadValidM;
   logic                         StallM;
   logic                         RegWriteW;
   logic [ADDR-1:0]              wa3w;
   logic [LANES-1:0][WIDTH-1:0]  wd3;
   logic                         PCWriteW;
`ifdef WB_LANE_MASK_EN
   logic [LANES-1:0]             LaneMaskM;
   logic [LANES-1:0]             WeLaneW;
`endif

   modport master (
`ifdef WB_LANE_MASK_EN
      output LaneMaskM, input WeLaneW,
`endif
      output ValidM, RegWriteM, MemtoRegM, wa3m, ALUResultM, ReadDataM, ReadValidM,
      input  StallM, RegWriteW, wa3w, wd3, PCWriteW
   );

   modport slave (
`ifdef WB_LANE_MASK_EN
      input LaneMaskM, output WeLaneW,
`endif
      input  ValidM, RegWriteM, MemtoRegM, wa3m, ALUResultM, ReadDataM, ReadValidM,
      output StallM, RegWriteW, wa3w, wd3, PCWriteW
   );
endinterface

// File: rtl/writeback_vec.sv
// Vector write-back stage: forwards ALU vectors, assembles one-lane-per-beat loads, drives the RF write port.
// Optional per-lane write mask enabled with WB_LANE_MASK_EN.
module writeback_vec #(
   parameter int WIDTH = 18,
   parameter int LANES = 3,
   parameter int ADDR  = 4
) (
   input logic           clk,
   input logic           rst,
   writeback_vec_if.slave bus
);
   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

   typedef logic [LANES-1:0][WIDTH-1:0] vec_t;
   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] lane_cnt_q, lane_cnt_d;
   vec_t             lanes_q, lanes_d;
   logic [ADDR-1:0]  ld_addr_q, ld_addr_d;
   logic             ld_we_q, ld_we_d;
   logic [LANES-1:0] mask_q, mask_d;
   logic             rw_q, rw_d;
   logic [ADDR-1:0]  wa3w_q, wa3w_d;
   vec_t             wd3_q, wd3_d;
   logic [LANES-1:0] in_mask, sel_mask;
`ifdef WB_LANE_MASK_EN
   logic [LANES-1:0] we_lane_q, we_lane_d;

   assign in_mask = bus.LaneMaskM;
`else
   assign in_mask = '1;
`endif

   function automatic vec_t apply_mask(input vec_t v, input logic [LANES-1:0] m);
      vec_t r;
      for (int i = 0; i < LANES; i++) r[i] = m[i] ? v[i] : '0;
      return r;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
      state_d    = state_q;
      lane_cnt_d = lane_cnt_q;
      lanes_d    = lanes_q;
      ld_addr_d  = ld_addr_q;
      ld_we_d    = ld_we_q;
      mask_d     = mask_q;
      rw_d       = 1'b0;
      wa3w_d     = wa3w_q;
      wd3_d      = wd3_q;
      sel_mask   = in_mask;

      unique case (state_q)
         IDLE, COMMIT: begin
            // COMMIT only presents the load's write; it accepts new work exactly like IDLE.
            state_d = IDLE;
            if (bus.ValidM) begin
               if (bus.MemtoRegM) begin
                  state_d    = LOAD;
                  lane_cnt_d = '0;
                  ld_addr_d  = bus.wa3m;
                  ld_we_d    = bus.RegWriteM;
                  mask_d     = in_mask;
               end else if (bus.RegWriteM) begin
                  rw_d   = 1'b1;
                  wa3w_d = bus.wa3m;
                  wd3_d  = apply_mask(bus.ALUResultM, in_mask);
               end
            end
         end
         LOAD: begin
            sel_mask = mask_q;
            if (bus.ReadValidM) begin
               lanes_d[lane_cnt_q] = bus.ReadDataM;
               lane_cnt_d          = lane_cnt_q + CNT_W'(1);
               if (lane_cnt_q == LAST) begin
                  state_d    = COMMIT;
                  lane_cnt_d = '0;
                  if (ld_we_q) begin
                     rw_d   = 1'b1;
                     wa3w_d = ld_addr_q;
                     wd3_d  = apply_mask(lanes_d, mask_q);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef WB_LANE_MASK_EN
      we_lane_d = rw_d ? sel_mask : '0;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         lane_cnt_q <= '0;
         rw_q       <= 1'b0;
         wa3w_q     <= '0;
         wd3_q      <= '0;
`ifdef WB_LANE_MASK_EN
         we_lane_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         lane_cnt_q <= lane_cnt_d;
         rw_q       <= rw_d;
         wa3w_q     <= wa3w_d;
         wd3_q      <= wd3_d;
`ifdef WB_LANE_MASK_EN
         we_lane_q  <= we_lane_d;
`endif
      end
   end

   // NOTE: lane buffer and load context are left unreset; they are always rewritten before LOAD reads them.
   always_ff @(posedge clk) begin
      lanes_q   <= lanes_d;
      ld_addr_q <= ld_addr_d;
      ld_we_q   <= ld_we_d;
      mask_q    <= mask_d;
   end

   assign bus.StallM    = (state_q == LOAD);
   assign bus.RegWriteW = rw_q;
   assign bus.wa3w      = wa3w_q;
   assign bus.wd3       = wd3_q;
   assign bus.PCWriteW  = rw_q && (&wa3w_q);
`ifdef WB_LANE_MASK_EN
   assign bus.WeLaneW   = we_lane_q;
`endif
endmodule
